eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
Frame-granular round-robin arbiter that merges NUM_PORTS AXI-Stream frame sources onto the single AXI-Stream input of the Ethernet TX path. Typical sources are ARP, ICMP and UDP frame builders, and the loopback output of the RX frame FIFO. A grant is held from the first beat of a frame through its tlast beat, so frames never interleave. An optional watchdog recovers the output if a granted source stalls mid-frame.

Parameters:
NUM_PORTS, 4, number of requesters; legal range 2..8.
DATA_WIDTH, 32, tdata width per port.
TIMEOUT, 256, watchdog limit: consecutive cycles with granted tvalid low inside a frame; legal range 1..65535.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed source data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
s_axis_tvalid  in  NUM_PORTS  per-source valid.
s_axis_tlast  in  NUM_PORTS  per-source last.
s_axis_tready  out  NUM_PORTS  per-source ready.
m_axis_tdata  out  DATA_WIDTH  merged data.
m_axis_tvalid  out  1  merged valid.
m_axis_tlast  out  1  merged last.
m_axis_tready  in  1  downstream ready.
grant  out  NUM_PORTS  one-hot current owner; zero when idle.
busy  out  1  high in any state other than IDLE.
frame_abort  out  1  one-cycle pulse when the watchdog terminates a frame.

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-low on aresetn.
- Reset values: state=IDLE, grant=0, last_grant index=NUM_PORTS-1, watchdog counter=0, frame_abort=0, busy=0.
  - All outputs are 0 at reset: m_axis_tvalid, m_axis_tlast, m_axis_tdata and s_axis_tready.
- States: IDLE, PASS, ABORT, DRAIN.
- IDLE:
  - s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is high, select the first requester searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Register grant (one-hot) and sel (index width $clog2(NUM_PORTS)), then move to PASS.
  - Arbitration costs exactly one cycle; the first beat is transferred no earlier than the cycle after the request is seen.
- PASS: combinational passthrough with zero latency and no extra buffering.
  - m_axis_tdata/tvalid/tlast = s_axis_*[sel].
  - s_axis_tready[sel] = m_axis_tready; all other s_axis_tready bits = 0.
  - On a handshake with tlast (m_axis_tvalid & m_axis_tready & m_axis_tlast): last_grant<=sel, grant<=0, go to IDLE.
  - Result: at least one idle cycle between consecutive frames.
- Requests arriving during PASS wait; they are never dropped and never preempt the current frame.
- A source that deasserts tvalid mid-frame keeps its grant; the output simply bubbles.
- A single-beat frame (tvalid and tlast in the same beat) completes PASS in one cycle.
- ABORT (watchdog only):
  - Drive m_axis_tvalid=1, m_axis_tlast=1, m_axis_tdata=0 and hold until m_axis_tready.
  - s_axis_tready[sel]=0.
  - After the handshake, go to DRAIN.
- DRAIN:
  - s_axis_tready[sel]=1 and m_axis_tvalid=0; beats from sel are discarded.
  - Exit to IDLE on a discarded beat with tlast, setting last_grant<=sel.
  - DRAIN itself has no timeout.
- Watchdog counter:
  - Increments in PASS while s_axis_tvalid[sel]=0.
  - Clears on any accepted beat and on entry to PASS.
  - Reaching TIMEOUT goes to ABORT and pulses frame_abort for one cycle.
  - Counter width is 16 bits and saturates, never wraps.
- Reset asserted mid-frame: all outputs drop immediately (asynchronously). The partial frame is not terminated downstream; the TX MAC is reset by the same aresetn.
- grant is always one-hot or zero and is stable for the whole frame.

Optional Feature:
ARB_WATCHDOG_EN:
- Defined: watchdog counter, ABORT and DRAIN states exist exactly as described above.
- Undefined: states ABORT and DRAIN and the counter are not built, and frame_abort is tied to 0. A stalled granted source then holds the output indefinitely.

Decomposition:
- Package eth_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t;
  - localparam ETH_AXIS_DATA_WIDTH=32;
  - function rr_next(req, last) returning the next index.
- Sub-module rr_pick: a purely combinational round-robin selector.
  - Inputs: req[NUM_PORTS] and last index.
  - Outputs: one-hot grant, index, and any flag.
  - Keeps the FSM file free of the priority-rotation logic.

Test Plan:
1. Reset release, no requests -> grant=0, busy=0, m_axis_tvalid=0 for 20 cycles.
2. Ports 0 and 2 both request 3-beat frames (0xA0..A2, 0xC0..C2), m_axis_tready=1 -> output order A0 A1 A2, one idle cycle, C0 C1 C2; tlast only on A2 and C2.
3. All 4 ports request continuously with 1-beat frames -> grant sequence 0,1,2,3,0 (starting from last_grant=3 after reset); no port served twice before the others.
4. m_axis_tready toggled 1-0-1 during a 4-beat frame from port 1 -> data order preserved, no beat lost or duplicated, s_axis_tready[1] mirrors m_axis_tready, port 3 request held off until tlast.
5. ARB_WATCHDOG_EN, TIMEOUT=8: port 0 sends 2 beats then drops tvalid -> after 8 cycles frame_abort pulses and output shows one beat tdata=0 with tlast=1. Port 0's remaining 3 beats (tlast on last) are absorbed with m_axis_tvalid=0, then port 1 is granted.
6. aresetn asserted mid-frame at beat 2 -> m_axis_tvalid, s_axis_tready and grant go to 0 within the same cycle. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// Shared types and the round-robin helper for the Ethernet TX frame arbiter.
package eth_arb_pkg;

  typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t;

  localparam int unsigned ETH_AXIS_DATA_WIDTH = 32;
  localparam int unsigned ARB_MAX_PORTS       = 8;
  localparam int unsigned ARB_IDX_W           = 3;

  // First requester strictly after 'last', wrapping modulo num_ports; returns 'last' if none.
  function automatic logic [ARB_IDX_W-1:0] rr_next(
    input logic [ARB_MAX_PORTS-1:0] req,
    input logic [ARB_IDX_W-1:0]     last,
    input int unsigned              num_ports
  );
    logic        found;
    int unsigned j;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAX_PORTS; k++) begin
      j = (32'(last) + k) % num_ports;
      if (k <= num_ports && !found && req[ARB_IDX_W'(j)]) begin
        rr_next = ARB_IDX_W'(j);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: next requester after the last owner.
module rr_pick
  import eth_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] onehot_c,
  output logic [IDX_W-1:0]     idx_c,
  output logic                 any_c
);

  logic [ARB_IDX_W-1:0] nxt_c;

  assign nxt_c    = rr_next(ARB_MAX_PORTS'(req), ARB_IDX_W'(last), NUM_PORTS);
  assign idx_c    = IDX_W'(nxt_c);
  assign onehot_c = NUM_PORTS'(1) << idx_c;
  assign any_c    = |req;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin merge of NUM_PORTS AXI-Stream sources onto the TX path.
// Define ARB_WATCHDOG_EN to build the stalled-source watchdog (ABORT/DRAIN states).
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = ETH_AXIS_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic                            frame_abort
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned WD_W  = 16;

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_d;
  logic [IDX_W-1:0]     sel_q, sel_d, last_q, last_d;
  logic [NUM_PORTS-1:0] pick_onehot_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 pick_any_c;
  logic [DATA_WIDTH-1:0] src_data_c [NUM_PORTS];
  logic                 sel_valid_c, sel_last_c;

`ifdef ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            abort_d;
`endif

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req      (s_axis_tvalid),
    .last     (last_q),
    .onehot_c (pick_onehot_c),
    .idx_c    (pick_idx_c),
    .any_c    (pick_any_c)
  );

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      src_data_c[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid_c = s_axis_tvalid[sel_q];
  assign sel_last_c  = s_axis_tlast[sel_q];
  assign busy        = (state_q != IDLE);

  // Next-state and passthrough; PASS is a zero-latency mux onto the owner.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant;
    sel_d         = sel_q;
    last_d        = last_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
`ifdef ARB_WATCHDOG_EN
    wd_d          = wd_q;
    abort_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          grant_d = pick_onehot_c;
          sel_d   = pick_idx_c;
          state_d = PASS;
`ifdef ARB_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      PASS: begin
        m_axis_tdata  = src_data_c[sel_q];
        m_axis_tvalid = sel_valid_c;
        m_axis_tlast  = sel_last_c;
        s_axis_tready = NUM_PORTS'(m_axis_tready) << sel_q;
        if (sel_valid_c && m_axis_tready) begin
`ifdef ARB_WATCHDOG_EN
          wd_d = '0;
`endif
          if (sel_last_c) begin
            last_d  = sel_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
`ifdef ARB_WATCHDOG_EN
        else if (!sel_valid_c) begin
          if (wd_q != '1) wd_d = wd_q + 1'b1;
          if (32'(wd_q) + 32'd1 >= TIMEOUT) begin
            state_d = ABORT;
            abort_d = 1'b1;
          end
        end
`endif
      end
`ifdef ARB_WATCHDOG_EN
      // Synthetic terminating beat so the MAC closes the truncated frame.
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_d = DRAIN;
      end
      DRAIN: begin
        s_axis_tready = NUM_PORTS'(1) << sel_q;
        if (sel_valid_c && sel_last_c) begin
          last_d  = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant  <= '0;
      sel_q  <= '0;
      last_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      grant  <= grant_d;
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q        <= '0;
      frame_abort <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      frame_abort <= abort_d;
    end
  end
`else
  assign frame_abort = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: frame-level round-robin reference model.
module tb_eth_tx_frame_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam int          LIMIT = 3000;

  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] data; logic last; int port; logic abrt; } exp_t;

  logic            aclk, aresetn;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [N-1:0]    grant;
  logic            busy, frame_abort;

  eth_tx_frame_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant(grant), .busy(busy), .frame_abort(frame_abort)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int    tests = 0, fails = 0;
  beat_t src_q [N][$];
  exp_t  exp_q [$];
  int    model_last = N - 1;
  int    rdy_mode = 0;
  int    stall0 = 0;
  int    abort_cnt = 0;
  logic  gap_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_frame(input int port, input int nbeats, input logic [31:0] base, input bit rnd);
    beat_t b;
    for (int j = 0; j < nbeats; j++) begin
      b.data = rnd ? $urandom : base + 32'(j);
      b.last = (j == nbeats - 1);
      src_q[port].push_back(b);
    end
  endtask

  // Reference: whole frames served in round-robin order over ports holding pending frames.
  task automatic build_expected();
    beat_t q [N][$];
    exp_t  e;
    int    p, c;
    for (int i = 0; i < N; i++) q[i] = src_q[i];
    while (1) begin
      p = -1;
      for (int k = 1; k <= N; k++) begin
        c = (model_last + k) % N;
        if (p < 0 && q[c].size() > 0) p = c;
      end
      if (p < 0) break;
      do begin
        e.data = q[p][0].data; e.last = q[p][0].last; e.port = p; e.abrt = 1'b0;
        void'(q[p].pop_front());
        exp_q.push_back(e);
      end while (!e.last);
      model_last = p;
    end
  endtask

  function automatic bit pending();
    pending = (exp_q.size() != 0) || busy;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) pending = 1'b1;
  endfunction

  task automatic wait_quiet(input string name);
    int cyc = 0;
    while (pending() && cyc < LIMIT) begin
      @(negedge aclk);
      cyc++;
    end
    check({name, "_timeout"}, 64'(cyc >= LIMIT), 64'd0);
    @(negedge aclk);
  endtask

  // Source driver: first beat held until accepted; bubbles only mid-frame.
  initial begin : driver
    logic [N-1:0] acc, held, mid;
    int    bub [N];
    int    pos [N];
    logic  vld;
    beat_t b;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    acc = '0; held = '0; mid = '0;
    for (int i = 0; i < N; i++) begin bub[i] = 0; pos[i] = 0; end
    forever begin
      @(negedge aclk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge aclk);
      #1;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        vld = 1'b0;
        if (!aresetn) begin
          held[i] = 1'b0; mid[i] = 1'b0; pos[i] = 0; bub[i] = 0;
        end else begin
          if (acc[i] && src_q[i].size() != 0) begin
            b = src_q[i].pop_front();
            held[i] = 1'b0;
            mid[i]  = !b.last;
            pos[i]  = b.last ? 0 : pos[i] + 1;
          end
          if (src_q[i].size() == 0) vld = 1'b0;
          else if (held[i]) vld = 1'b1;
          else if (i == 0 && stall0 > 0 && pos[0] == 2) begin vld = 1'b0; stall0--; end
          else if (mid[i] && bub[i] < 3 && $urandom_range(0, 3) == 0) begin vld = 1'b0; bub[i]++; end
          else vld = 1'b1;
          if (vld) bub[i] = 0;
          held[i] = vld;
        end
        s_axis_tvalid[i] = vld;
        s_axis_tlast[i]  = (src_q[i].size() != 0) ? src_q[i][0].last : 1'b0;
        s_axis_tdata[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0].data : '0;
      end
    end
  end

  // Monitor: compares every output handshake against the scoreboard head.
  initial begin : monitor
    exp_t         e;
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
        if (frame_abort) abort_cnt++;
        if (gap_req) check("idle_gap", 64'(m_axis_tvalid), 64'd0);
        gap_req = 1'b0;
        if (m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
          end else begin
            e = exp_q[0];
            exp_rdy = (e.abrt || !m_axis_tready) ? '0 : (N'(1) << e.port);
            check("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            check("grant", 64'(grant), 64'(N'(1) << e.port));
            if (m_axis_tready) begin
              void'(exp_q.pop_front());
              check("tdata", 64'(m_axis_tdata), 64'(e.data));
              check("tlast", 64'(m_axis_tlast), 64'(e.last));
              gap_req = e.last;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    int   cyc;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mlast", 64'(m_axis_tlast), 64'd0);
    check("rst_mdata", 64'(m_axis_tdata), 64'd0);
    check("rst_sready", 64'(s_axis_tready), 64'd0);
    check("rst_abort", 64'(frame_abort), 64'd0);
    aresetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_mvalid", 64'(m_axis_tvalid), 64'd0);
      check("idle_grant", 64'(grant), 64'd0);
    end

    rdy_mode = 0;
    load_frame(0, 3, 32'hA0, 1'b0);
    load_frame(2, 3, 32'hC0, 1'b0);
    build_expected();
    wait_quiet("two_ports");

    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) load_frame(i, 1, 32'h100 + 32'(i), 1'b0);
    build_expected();
    wait_quiet("single_beats");

    rdy_mode = 1;
    load_frame(1, 4, 32'h10, 1'b0);
    load_frame(3, 2, 32'h30, 1'b0);
    build_expected();
    wait_quiet("backpressure");

    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < N; i++) begin
        int nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) load_frame(i, $urandom_range(1, 5), 32'h0, 1'b1);
      end
      build_expected();
      wait_quiet("random");
    end

`ifdef ARB_WATCHDOG_EN
    rdy_mode = 0;
    abort_cnt = 0;
    stall0 = 12;
    load_frame(0, 5, 32'hB0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      e.data = 32'hB0 + 32'(j); e.last = 1'b0; e.port = 0; e.abrt = 1'b0;
      exp_q.push_back(e);
    end
    e.data = 32'h0; e.last = 1'b1; e.port = 0; e.abrt = 1'b1;
    exp_q.push_back(e);
    wait_quiet("watchdog");
    check("abort_pulses", 64'(abort_cnt), 64'd1);
    model_last = 0;
    load_frame(1, 1, 32'hD0, 1'b0);
    build_expected();
    wait_quiet("after_abort");
`endif

    rdy_mode = 0;
    load_frame(1, 6, 32'hE0, 1'b0);
    build_expected();
    cyc = 0;
    while (exp_q.size() > 4 && cyc < LIMIT) begin
      @(negedge aclk);
      cyc++;
    end
    check("mid_frame_timeout", 64'(cyc >= LIMIT), 64'd0);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_sready", 64'(s_axis_tready), 64'd0);
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    model_last = N - 1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) load_frame(i, 2, 32'hF0 + 32'(i * 16), 1'b0);
    build_expected();
    check("post_rst_first_port", 64'(exp_q[0].port), 64'd0);
    wait_quiet("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : global_guard
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
